uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated byte FIFO. It extends the fixed-configuration UART TX with a runtime baud divisor, 7/8 data bits, optional odd/even parity, 1/2 stop bits and write-side buffering. It sits between the host write interface and the serial pin `tx`. The FSM drains the FIFO frame by frame with no idle gap between back-to-back frames.

Parameters:
DIV_W, 16, width of baud_div input.
FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2.
CNT_W, $clog2(FIFO_DEPTH)+1, width of level output (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
baud_div  in  DIV_W  bit period minus one, in clk cycles (0 gives 1 clk/bit).
eight  in  1  1 = 8 data bits, 0 = 7 data bits (wr_data[7] not sent).
pen  in  1  parity enable.
ohel  in  1  parity sense: 1 = odd, 0 = even; ignored when pen=0.
two_stop  in  1  1 = two stop bits, 0 = one.
wr_data  in  8  byte to enqueue.
wr_en  in  1  enqueue strobe, one byte per cycle.
full  out  1  FIFO holds FIFO_DEPTH entries.
empty  out  1  FIFO holds 0 entries.
level  out  CNT_W  current FIFO occupancy.
overflow  out  1  one-cycle pulse when wr_en is dropped because full=1.
busy  out  1  high from the start bit through the last stop bit.
tx  out  1  registered serial output, idle high.

Behaviour:
- Reset: tx=1, busy=0, overflow=0, empty=1, full=0, level=0. FIFO is flushed. FSM goes to IDLE. Reset mid-frame aborts the frame: tx is 1 in the cycle after rst is sampled high.
- FIFO: write is accepted iff wr_en=1 and full=0 at that edge. There is no write bypass when full, even if a pop happens in the same cycle. Simultaneous push and pop leaves level unchanged. full, empty and level are registered and reflect the state after the edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if empty=0, pop the head into the shift register and latch baud_div, eight, pen, ohel and two_stop. Go to START.
- Configuration is frozen per frame. Input changes mid-frame take effect at the next frame.
- Each state lasts baud_div+1 cycles, timed by a down-counter reloaded on every bit.
- START: tx=0.
- DATA: LSB first, 8 or 7 bits.
- PARITY: entered only if pen=1. Parity bit = XOR of the sent data bits, inverted when ohel=1 (odd).
- STOP: tx=1 for 1 or 2 bit periods.
- After STOP, if empty=0, pop immediately and enter START with no idle bit. Otherwise return to IDLE.
- Frame length in bits = 1 + (eight ? 8 : 7) + pen + (two_stop ? 2 : 1).
- Latency: a write in cycle N into an empty FIFO with the FSM idle gives a pop at edge N+1 and tx=0 from edge N+2.
- busy drops in the cycle the FSM re-enters IDLE.

Optional Feature:
UART_TX_BREAK_EN.
- Defined: adds input `send_break`, 1 bit. When sampled high in IDLE, or at frame end, the FSM enters a BREAK state with tx=0 and busy=1. No pops occur while it is held. Deassertion gives one stop-length mark (tx=1) and then normal operation.
- Undefined: port and BREAK state are absent.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK) and a parity function parity_bit(data, eight, odd).
- Sub-module: sync_fifo (parameter WIDTH=8, DEPTH=FIFO_DEPTH) provides full, empty and level. The FSM, baud counter and shifter live in uart_tx_fifo.

Test Plan:
1. 8N1 (eight=1, pen=0, two_stop=0), baud_div=3, write 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 at 4 clk/bit (40 clks); busy high for exactly 40 clks.
2. 7E1 (eight=0, pen=1, ohel=0), write 0xA5 -> start 0, data 1,0,1,0,0,1,0, parity 1, stop 1. Repeat with ohel=1 -> parity 0.
3. 8O2 (eight=1, pen=1, ohel=1, two_stop=1), write 0xA5 -> parity 1 and two stop bits, 12 bits total.
4. Back-to-back: write 0x55 then 0x0F -> the second start bit directly follows the first stop bit with no extra idle, and empty=1 after the second pop.
5. Overflow: 18 writes on consecutive cycles, baud_div=100 -> 17 bytes accepted (one already in the shifter), full=1, overflow pulses once on the 18th write, level=16; all 17 bytes are later received in order.
6. Reset mid-DATA -> next cycle tx=1, busy=0, empty=1, level=0. Changing baud_div mid-frame does not alter the current frame's bit period.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter (uart_tx_fifo).
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  // Per-frame configuration captured at the moment a byte is popped.
  typedef struct packed {
    logic eight;
    logic pen;
    logic ohel;
    logic two_stop;
  } frame_cfg_t;

  // XOR of the bits actually sent (bit 7 dropped in 7-bit mode), inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data,
                                      input logic              eight,
                                      input logic              odd);
    logic [DATA_W-1:0] sent;
    sent = eight ? data : {1'b0, data[DATA_W-2:0]};
    return (^sent) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a registered drop pulse.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    level,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             push;
  logic             pop;

  // Writes are judged against the registered full flag only; a same-cycle pop never frees a slot.
  always_comb begin
    push       = wr_en && !full_q;
    pop        = rd_en && !empty_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + CW'(push) - CW'(pop);
    full_d     = (level_d == CW'(DEPTH));
    empty_d    = (level_d == '0);
    overflow_d = wr_en && full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a byte FIFO with runtime baud/format; frames run back to back.
// Optional line-break generation is enabled with `define UART_TX_BREAK_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DIV_W      = 16,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic              two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic              send_break,
`endif
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  level,
  output logic              overflow,
  output logic              busy,
  output logic              tx
);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  frame_cfg_t        cfg_q, cfg_d;
  frame_cfg_t        cfg_in;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] head;
  logic              pop;
  logic              bit_done;
  logic              start_frame;
  logic              enter_break;
  logic              brk_req;

`ifdef UART_TX_BREAK_EN
  assign brk_req = send_break;
`else
  assign brk_req = 1'b0;
`endif

  assign cfg_in   = '{eight: eight, pen: pen, ohel: ohel, two_stop: two_stop};
  assign bit_done = (cnt_q == '0);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus bit timing; a new frame or break latches its own copy of the configuration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    cfg_d       = cfg_q;
    data_d      = data_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    enter_break = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_done ? div_q : cnt_q - DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (brk_req) begin
          enter_break = 1'b1;
        end else if (!empty) begin
          start_frame = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == (cfg_q.eight ? 3'd7 : 3'd6)) begin
            state_d    = cfg_q.pen ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (cfg_q.two_stop && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (brk_req) begin
            enter_break = 1'b1;
          end else if (!empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // Releasing the break leaves a single mark bit before the line is free again.
      BREAK: begin
        if (!brk_req) begin
          state_d    = STOP;
          stop_idx_d = 1'b1;
          cnt_d      = div_q;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_frame) begin
      pop     = 1'b1;
      data_d  = head;
      cfg_d   = cfg_in;
      div_d   = baud_div;
      cnt_d   = baud_div;
      state_d = START;
    end

    if (enter_break) begin
      cfg_d   = cfg_in;
      div_d   = baud_div;
      cnt_d   = baud_div;
      state_d = BREAK;
    end
  end

  // Line level and busy follow the current state one register stage later.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_q)
      IDLE:   busy_d = 1'b0;
      START:  tx_d   = 1'b0;
      DATA:   tx_d   = data_q[bit_idx_q];
      PARITY: tx_d   = parity_bit(data_q, cfg_q.eight, cfg_q.ohel);
      STOP:   tx_d   = 1'b1;
`ifdef UART_TX_BREAK_EN
      BREAK:  tx_d   = 1'b0;
`endif
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= '0;
      cfg_q      <= '0;
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      cfg_q      <= cfg_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level waveform model compared every cycle plus literal frame checks.
module tb_uart_tx_fifo;

  localparam int unsigned DIV_W      = 16;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [DIV_W-1:0] baud_div;
  logic             eight;
  logic             pen;
  logic             ohel;
  logic             two_stop;
  logic [7:0]       wr_data;
  logic             wr_en;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] level;
  logic             overflow;
  logic             busy;
  logic             tx;
`ifdef UART_TX_BREAK_EN
  logic             send_break;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .eight      (eight),
    .pen        (pen),
    .ohel       (ohel),
    .two_stop   (two_stop),
`ifdef UART_TX_BREAK_EN
    .send_break (send_break),
`endif
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .busy       (busy),
    .tx         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: byte queue for the FIFO, per-cycle line samples for the frame in flight.
  logic [7:0] mq [$];
  logic       txq [$];
  int         m_cnt       = 0;
  logic       exp_tx      = 1'b1;
  logic       exp_busy    = 1'b0;
  logic       exp_ovf     = 1'b0;
  bit         model_valid = 1'b0;
  int         busy_cycles = 0;
  int         ovf_count   = 0;

  function automatic void append_frame(input logic [7:0] b);
    logic bits [$];
    logic p;
    int   nd;
    p  = 1'b0;
    nd = eight ? 8 : 7;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      bits.push_back(b[i]);
      p = p ^ b[i];
    end
    if (pen) bits.push_back(p ^ ohel);
    bits.push_back(1'b1);
    if (two_stop) bits.push_back(1'b1);
    foreach (bits[j]) begin
      for (int r = 0; r <= int'(baud_div); r++) txq.push_back(bits[j]);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      txq.delete();
      exp_tx      <= 1'b1;
      exp_busy    <= 1'b0;
      exp_ovf     <= 1'b0;
      m_cnt       <= 0;
      model_valid <= 1'b1;
    end else begin
      if (txq.size() > 0) begin
        exp_tx   <= txq.pop_front();
        exp_busy <= 1'b1;
      end else begin
        exp_tx   <= 1'b1;
        exp_busy <= 1'b0;
      end
      if (txq.size() == 0 && mq.size() > 0) append_frame(mq.pop_front());
      if (wr_en && m_cnt < int'(FIFO_DEPTH)) mq.push_back(wr_data);
      exp_ovf <= wr_en && (m_cnt == int'(FIFO_DEPTH));
      m_cnt   <= mq.size();
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("tx", 32'(tx), 32'(exp_tx));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("level", 32'(level), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == int'(FIFO_DEPTH)));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      if (busy) busy_cycles <= busy_cycles + 1;
      if (overflow) ovf_count <= ovf_count + 1;
    end
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int t;
    t = 0;
    while (busy !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_start"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy === 1'b1 && t < 30000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // seq holds the expected line bits in transmission order, left to right, right-aligned.
  task automatic frame_check(input string name, input logic [11:0] seq, input int n,
                             input int bits_per, input int exp_len);
    int k;
    k = 0;
    wait_busy(name);
    while (busy === 1'b1 && k < 20000) begin
      if ((k % bits_per) == 0 && (k / bits_per) < n)
        chk($sformatf("%s_bit%0d", name, k / bits_per), 32'(tx), 32'(seq[n-1-k/bits_per]));
      @(negedge clk);
      k++;
    end
    chk({name, "_len"}, 32'(k), 32'(exp_len));
  endtask

  initial begin
    int ovf0;
    int busy0;
    rst      = 1'b1;
    baud_div = 16'd3;
    eight    = 1'b1;
    pen      = 1'b0;
    ohel     = 1'b0;
    two_stop = 1'b0;
    wr_data  = 8'h00;
    wr_en    = 1'b0;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);

    // 8N1, 4 clk/bit
    write_byte(8'hA5);
    frame_check("8n1", 12'b0101001011, 10, 4, 40);

    // 7E1 then 7O1
    eight = 1'b0; pen = 1'b1; ohel = 1'b0;
    write_byte(8'hA5);
    frame_check("7e1", 12'b0101001011, 10, 4, 40);
    ohel = 1'b1;
    write_byte(8'hA5);
    frame_check("7o1", 12'b0101001001, 10, 4, 40);

    // 8O2
    eight = 1'b1; pen = 1'b1; ohel = 1'b1; two_stop = 1'b1;
    write_byte(8'hA5);
    frame_check("8o2", 12'b010100101111, 12, 4, 48);

    // back-to-back frames
    pen = 1'b0; ohel = 1'b0; two_stop = 1'b0;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk); wr_data = 8'h0F;
    @(negedge clk); wr_en = 1'b0;
    wait_busy("b2b");
    chk("b2b_level", 32'(level), 32'd1);
    repeat (40) @(negedge clk);
    chk("b2b_start2", 32'(tx), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_empty", 32'(empty), 32'd1);
    wait_idle("b2b");

    // overflow with a slow line
    baud_div = 16'd100;
    ovf0  = ovf_count;
    busy0 = busy_cycles;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'(8'h10 + i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    wait_idle("ovf");
    chk("ovf_count", 32'(ovf_count - ovf0), 32'd1);
    chk("ovf_busy_len", 32'(busy_cycles - busy0), 32'd17170);
    chk("ovf_drained", 32'(empty), 32'd1);

    // reset in the middle of a data bit with bytes still queued
    baud_div = 16'd3;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk); wr_data = 8'h81;
    @(negedge clk); wr_data = 8'h7E;
    @(negedge clk); wr_en = 1'b0;
    wait_busy("rstmid");
    repeat (8) @(negedge clk);
    chk("rstmid_pre_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_tx", 32'(tx), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_empty", 32'(empty), 32'd1);
    chk("rstmid_level", 32'(level), 32'd0);

    // baud_div change mid-frame only affects the next frame
    write_byte(8'hC3);
    fork
      frame_check("divhold", 12'b0110000111, 10, 4, 40);
      begin
        repeat (12) @(negedge clk);
        baud_div = 16'd7;
      end
    join
    write_byte(8'h01);
    frame_check("divnext", 12'b0100000001, 10, 8, 80);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
